// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, LSB-first payload, optional even parity, stop bit.
// Good frames land in a one-entry valid/ready buffer; parity/stop failures pulse frame_err.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | line idle, waiting for a low start bit
// DATA      | shifting in DATA_BITS payload bits, LSB first
// PARITY    | sampling the even-parity bit
// STOP      | sampling the stop bit, frame accepted or rejected here
// WAIT_IDLE | after a missing stop bit, wait for the line to return high
module serial_frame_rx #(
    parameter int DATA_BITS = 8,
    parameter int PARITY_EN = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 din,
    output logic [DATA_BITS-1:0] frame_data,
    output logic                 frame_valid,
    input  logic                 frame_ready,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int CW = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 par_err_q, par_err_d;
    logic                 valid_q, valid_d;
    logic                 err_q, err_d;
    logic                 ovr_q, ovr_d;
    logic                 good;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            par_err_q <= 1'b0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            par_err_q <= par_err_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            ovr_q     <= ovr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        par_err_d = par_err_q;
        good      = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (!din) begin
                    state_d   = DATA;
                    cnt_d     = '0;
                    par_err_d = 1'b0;
                end
            end
            DATA: begin
                shift_d = {din, shift_q[DATA_BITS-1:1]};
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(DATA_BITS - 1)) begin
                    state_d = (PARITY_EN != 0) ? PARITY : STOP;
                end
            end
            PARITY: begin
                par_err_d = (^shift_q) ^ din;
                state_d   = STOP;
            end
            STOP: begin
                if (din && !par_err_q) begin
                    good    = 1'b1;
                    state_d = IDLE;
                end else if (din) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    err_d   = 1'b1;
                    state_d = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (din) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A full buffer keeps its frame; the newcomer is dropped and flagged.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ovr_d   = 1'b0;
        if (good) begin
            if (!valid_q || frame_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && frame_ready) begin
            valid_d = 1'b0;
        end
    end

    assign frame_data  = data_q;
    assign frame_valid = valid_q;
    assign frame_err   = err_q;
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: frames are composed into a per-cycle line/ready stream,
// with the expected buffer and error outcome derived per frame and checked every cycle.
module tb_serial_frame_rx;

    localparam int DB   = 8;
    localparam int MAXC = 8192;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          din = 1'b1;
    logic          frame_ready = 1'b0;
    logic [DB-1:0] frame_data;
    logic          frame_valid;
    logic          frame_err;
    logic          overrun;

    serial_frame_rx #(.DATA_BITS(DB), .PARITY_EN(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_err   (frame_err),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    // Stream: line value, ready value, and frame outcome (0 none, 1 good, 2 error) per cycle.
    bit            din_a [MAXC];
    bit            rdy_a [MAXC];
    int            ev_k  [MAXC];
    logic [DB-1:0] ev_d  [MAXC];
    int            len   = 0;
    int            ptr   = 0;
    int            rmode = 1;
    int            n_cmp = 0;
    int            n_mis = 0;

    bit            mv = 1'b0;
    logic [DB-1:0] md = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s at step %0d: observed=%0h expected=%0h", tag, ptr, obs, expv);
        end
    endtask

    task automatic add_bit(input bit b);
        if (len >= MAXC) begin
            $display("FAIL stream_overflow: length %0d exceeds %0d", len, MAXC);
            $fatal(1, "stream overflow");
        end
        din_a[len] = b;
        rdy_a[len] = (rmode == 2) ? bit'($urandom_range(0, 1)) : bit'(rmode);
        ev_k[len]  = 0;
        ev_d[len]  = '0;
        len++;
    endtask

    task automatic add_idle(input int n);
        repeat (n) add_bit(1'b1);
    endtask

    task automatic add_frame(input logic [DB-1:0] d, input bit bad_par, input bit bad_stop,
                             input int lowhold);
        int s;
        add_bit(1'b0);
        for (int i = 0; i < DB; i++) add_bit(d[i]);
        add_bit((^d) ^ bad_par);
        s = len;
        add_bit(!bad_stop);
        ev_k[s] = (bad_par || bad_stop) ? 2 : 1;
        ev_d[s] = d;
        if (bad_stop) begin
            repeat (lowhold) add_bit(1'b0);
            add_bit(1'b1);
        end
    endtask

    task automatic run_stream();
        bit e_err, e_ovr;
        while (ptr < len) begin
            @(negedge clk);
            din         = din_a[ptr];
            frame_ready = rdy_a[ptr];
            @(posedge clk);
            #1;
            e_err = (ev_k[ptr] == 2);
            e_ovr = 1'b0;
            if (ev_k[ptr] == 1) begin
                if (!mv || rdy_a[ptr]) begin
                    md = ev_d[ptr];
                    mv = 1'b1;
                end else begin
                    e_ovr = 1'b1;
                end
            end else if (mv && rdy_a[ptr]) begin
                mv = 1'b0;
            end
            check("frame_valid", 32'(frame_valid), 32'(mv));
            check("frame_data",  32'(frame_data),  32'(md));
            check("frame_err",   32'(frame_err),   32'(e_err));
            check("overrun",     32'(overrun),     32'(e_ovr));
            ptr++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(frame_valid), 32'd0);
        check({tag, "_data"},  32'(frame_data),  32'd0);
        check({tag, "_err"},   32'(frame_err),   32'd0);
        check({tag, "_ovr"},   32'(overrun),     32'd0);
    endtask

    initial begin
        int kind;
        #1;
        check_reset_outputs("por");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Good frame 0xA5, held until ready rises.
        rmode = 0;
        add_idle(1);
        add_frame(8'hA5, 1'b0, 1'b0, 0);
        add_idle(2);
        rmode = 1;
        add_idle(2);

        // Parity error, then a good frame straight after.
        add_frame(8'hA5, 1'b1, 1'b0, 0);
        add_frame(8'h5A, 1'b0, 1'b0, 0);
        add_idle(2);

        // Missing stop bit with line held low, then 0x3C.
        rmode = 0;
        add_frame(8'hC3, 1'b0, 1'b1, 2);
        add_frame(8'h3C, 1'b0, 1'b0, 0);
        add_idle(2);
        rmode = 1;
        add_idle(2);

        // Back-to-back frames with the consumer always ready.
        add_frame(8'h12, 1'b0, 1'b0, 0);
        add_frame(8'h34, 1'b0, 1'b0, 0);
        add_idle(3);

        // Consumer stalled: second frame overruns, first frame survives.
        rmode = 0;
        add_frame(8'h55, 1'b0, 1'b0, 0);
        add_frame(8'hAA, 1'b0, 1'b0, 0);
        add_idle(3);
        rmode = 1;
        add_idle(3);
        run_stream();

        // Reset in the middle of a frame while an old frame is still buffered.
        rmode = 0;
        add_frame(8'h77, 1'b0, 1'b0, 0);
        add_idle(1);
        add_bit(1'b0);
        for (int i = 0; i < 4; i++) add_bit(bit'($urandom_range(0, 1)));
        run_stream();
        @(negedge clk);
        #2;
        rst = 1'b1;
        din = 1'b0;
        #1;
        check_reset_outputs("rst_async");
        @(posedge clk);
        #1;
        check_reset_outputs("rst_hold");
        @(negedge clk);
        rst = 1'b0;
        din = 1'b1;
        mv  = 1'b0;
        md  = '0;
        add_frame(8'h81, 1'b0, 1'b0, 0);
        add_idle(2);
        rmode = 1;
        add_idle(2);
        run_stream();

        // Randomized mix of good, parity-error and stop-error frames with random ready.
        rmode = 2;
        for (int f = 0; f < 60; f++) begin
            kind = int'($urandom_range(0, 3));
            add_frame(DB'($urandom), kind == 2, kind == 3, int'($urandom_range(0, 3)));
            add_idle(int'($urandom_range(0, 2)));
        end
        rmode = 1;
        add_idle(3);
        run_stream();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
